// File: rtl/gate_seq_ctrl.sv
// Steps a 2-input gate through vectors 00,01,10,11, holding each for HOLD_CYCLES
// cycles before sampling z against EXPECT_TT. Reports pass, error count and mask.
module gate_seq_ctrl #(
  parameter int         HOLD_CYCLES = 2,
  parameter logic [3:0] EXPECT_TT   = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_x,
  output logic       gate_y,
  input  logic       gate_z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          gate_x_q, gate_x_d;
  logic          gate_y_q, gate_y_d;
  logic          pass_q, pass_d;
  logic [2:0]    err_count_q, err_count_d;
  logic [3:0]    err_mask_q, err_mask_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 2'd0;
      hold_cnt_q  <= '0;
      gate_x_q    <= 1'b0;
      gate_y_q    <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hold_cnt_q  <= hold_cnt_d;
      gate_x_q    <= gate_x_d;
      gate_y_q    <= gate_y_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    hold_cnt_d  = hold_cnt_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    gate_x_d    = 1'b0;
    gate_y_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_DRIVE;
          vec_d       = 2'd0;
          hold_cnt_d  = '0;
          pass_d      = 1'b0;
          err_count_d = 3'd0;
          err_mask_d  = 4'd0;
        end
      end
      S_DRIVE: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (gate_z != EXPECT_TT[vec_q]) begin
          err_mask_d[vec_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
          pass_d  = (err_count_d == 3'd0);
        end else begin
          vec_d      = vec_q + 2'd1;
          hold_cnt_d = '0;
          state_d    = S_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops follow the state being entered so x/y change on the same edge as the FSM.
    if (state_d == S_DRIVE || state_d == S_SAMPLE) begin
      gate_x_d = vec_d[1];
      gate_y_d = vec_d[0];
    end
  end

  assign gate_x    = gate_x_q;
  assign gate_y    = gate_y_q;
  assign busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: two instances (HOLD_CYCLES 2 and 1) driving modelled gates
// with chosen or random truth tables, checked cycle by cycle against a schedule model.
module tb_gate_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      start;
  logic [1:0]      gx, gy, busy, done, pass;
  logic            gz0, gz1;
  logic [1:0][2:0] ec;
  logic [1:0][3:0] em;
  logic [1:0][3:0] tt;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] EXP_TT = 4'b1110;

  assign gz0 = tt[0][{gx[0], gy[0]}];
  assign gz1 = tt[1][{gx[1], gy[1]}];

  gate_seq_ctrl #(.HOLD_CYCLES(2), .EXPECT_TT(EXP_TT)) u_dut_h2 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .gate_x(gx[0]), .gate_y(gy[0]), .gate_z(gz0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(ec[0]), .err_mask(em[0])
  );

  gate_seq_ctrl #(.HOLD_CYCLES(1), .EXPECT_TT(EXP_TT)) u_dut_h1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .gate_x(gx[1]), .gate_y(gy[1]), .gate_z(gz1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(ec[1]), .err_mask(em[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic poke(input int pm);
    if (pm == 1) return 1'b1;
    if (pm == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic check_all_zero(input int d, input string tag);
    chk({tag, "_xy"}, {gx[d], gy[d]}, 0);
    chk({tag, "_busy"}, busy[d], 0);
    chk({tag, "_done"}, done[d], 0);
    chk({tag, "_pass"}, pass[d], 0);
    chk({tag, "_cnt"}, ec[d], 0);
    chk({tag, "_mask"}, em[d], 0);
  endtask

  // Called at a negedge with the instance in IDLE; returns at a negedge in IDLE.
  // pm: 0 no extra start, 1 start held high throughout, 2 random start pokes.
  task automatic run(input int d, input logic [3:0] g, input int pm);
    int         h, n;
    logic [3:0] xm;
    h  = (d == 0) ? 2 : 1;
    n  = 4 * (h + 1);
    xm = g ^ EXP_TT;
    tt[d] = g;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("clr_cnt", ec[d], 0);
    chk("clr_mask", em[d], 0);
    chk("clr_pass", pass[d], 0);
    for (int k = 1; k <= n; k++) begin
      chk("vec", {gx[d], gy[d]}, (k - 1) / (h + 1));
      chk("busy", busy[d], 1);
      chk("done_early", done[d], 0);
      start[d] = poke(pm);
      @(negedge clk);
    end
    chk("done", done[d], 1);
    chk("busy_done", busy[d], 0);
    chk("xy_done", {gx[d], gy[d]}, 0);
    chk("pass", pass[d], (xm == 4'd0) ? 1 : 0);
    chk("err_count", ec[d], $countones(xm));
    chk("err_mask", em[d], xm);
    start[d] = poke(pm);
    @(negedge clk);
    start[d] = 1'b0;
    chk("done_once", done[d], 0);
    chk("busy_idle", busy[d], 0);
    chk("xy_idle", {gx[d], gy[d]}, 0);
    chk("pass_hold", pass[d], (xm == 4'd0) ? 1 : 0);
    chk("cnt_hold", ec[d], $countones(xm));
    chk("mask_hold", em[d], xm);
  endtask

  // Reset lands at the edge closing run cycle 'cut', with start raised too.
  task automatic abort(input int d, input int cut);
    tt[d] = 4'($urandom);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    repeat (cut - 1) @(negedge clk);
    rst[d] = 1'b1;
    start[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    start[d] = 1'b0;
    check_all_zero(d, "abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done[d], 0);
      chk("abort_busy", busy[d], 0);
    end
  endtask

  initial begin
    rst   = 2'b11;
    start = 2'b00;
    tt[0] = 4'b1110;
    tt[1] = 4'b1110;
    repeat (2) @(negedge clk);
    check_all_zero(0, "rst0");
    check_all_zero(1, "rst1");
    rst = 2'b00;
    @(negedge clk);

    run(0, 4'b1110, 0);
    run(0, 4'b1000, 1);
    run(0, 4'b1111, 2);
    run(0, 4'b0000, 0);
    run(0, 4'b1110, 2);
    abort(0, 6);
    run(0, 4'b1110, 0);
    abort(0, int'($urandom_range(1, 12)));
    run(0, 4'b1000, 0);
    for (int i = 0; i < 20; i++) begin
      run(0, 4'($urandom), int'($urandom_range(0, 2)));
    end

    run(1, 4'b1110, 0);
    abort(1, int'($urandom_range(1, 8)));
    for (int i = 0; i < 10; i++) begin
      run(1, 4'($urandom), int'($urandom_range(0, 2)));
    end
    run(1, 4'b1110, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
